// File: rtl/icache_line_fetcher_pkg.sv
// Shared types and constants for the instruction line fetcher.
package icache_line_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam int LINE_BYTES     = 64;
  localparam int INSTS_PER_LINE = 16;
  localparam int BEATS_PER_LINE = 512 / 128;

  function automatic int beats_per_line(input int line_w, input int mem_w);
    return line_w / mem_w;
  endfunction

  function automatic logic [63:0] line_align(input logic [63:0] pc);
    return {pc[63:6], 6'd0};
  endfunction

endpackage

// File: rtl/icache_line_fetcher.sv
// Line fetcher: grant + BEATS beats + 1 hold cycle per line; line held stable while instq_full_i.
// Redirect drains outstanding beats before re-requesting; ICACHE_FETCH_PERF_EN adds perf counters.
module icache_line_fetcher
  import icache_line_fetcher_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          MEM_DATA_W = 128,
  parameter int          LINE_W     = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req_o,
  output logic [63:0]           mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i,
  output logic                  icache_valid_o,
  output logic [63:0]           icache_pc_o,
  output logic [LINE_W-1:0]     icache_data_o,
  input  logic                  instq_full_i,
  input  logic                  redirect_i,
  input  logic [63:0]           redirect_pc_i,
  output logic [31:0]           perf_lines_o,
  output logic [31:0]           perf_stall_o
);

  localparam int BEATS = beats_per_line(LINE_W, MEM_DATA_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] REQ   = ST_REQ;
  localparam logic [1:0] FILL  = ST_FILL;
  localparam logic [1:0] HOLD  = ST_HOLD;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  logic [1:0]        state;
  logic [63:0]       fetch_pc;
  logic [63:0]       pend_pc;
  logic [63:0]       out_pc;
  logic [CNT_W-1:0]  beat_cnt;
  logic [LINE_W-1:0] fill_buf;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] assembled;
  logic [63:0]       target;
  logic              last_beat;
  logic              transfer;
  logic              unused_pc_lsb;

  assign target        = line_align(redirect_pc_i);
  assign unused_pc_lsb = ^redirect_pc_i[5:0];
  assign last_beat     = (beat_cnt == LAST_BEAT);

  assign mem_req_o      = (state == REQ);
  assign mem_addr_o     = fetch_pc;
  assign icache_valid_o = (state == HOLD) && !redirect_i;
  assign icache_pc_o    = out_pc;
  assign icache_data_o  = line_buf;
  assign transfer       = icache_valid_o && !instq_full_i;

  // Partial beats collect in fill_buf so the visible line only changes when a new line completes.
  always_comb begin
    assembled = fill_buf;
    assembled[int'(beat_cnt) * MEM_DATA_W +: MEM_DATA_W] = mem_rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      out_pc   <= RESET_PC;
      beat_cnt <= '0;
      fill_buf <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_i) begin
            if (mem_gnt_i) begin
              pend_pc  <= target;
              beat_cnt <= '0;
              state    <= DRAIN;
            end else begin
              fetch_pc <= target;
            end
          end else if (mem_gnt_i) begin
            beat_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (redirect_i) begin
            pend_pc <= target;
            // A final beat landing with the redirect leaves nothing to drain.
            if (mem_rvalid_i && last_beat) begin
              fetch_pc <= target;
              state    <= REQ;
            end else begin
              state <= DRAIN;
              if (mem_rvalid_i) beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end else if (mem_rvalid_i) begin
            fill_buf <= assembled;
            if (last_beat) begin
              line_buf <= assembled;
              out_pc   <= fetch_pc;
              state    <= HOLD;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (redirect_i) begin
            fetch_pc <= target;
            state    <= REQ;
          end else if (!instq_full_i) begin
            fetch_pc <= fetch_pc + 64'(LINE_BYTES);
            state    <= REQ;
          end
        end
        DRAIN: begin
          if (mem_rvalid_i && last_beat) begin
            fetch_pc <= redirect_i ? target : pend_pc;
            state    <= REQ;
          end else begin
            if (redirect_i)   pend_pc  <= target;
            if (mem_rvalid_i) beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= REQ;
      endcase
    end
  end

`ifdef ICACHE_FETCH_PERF_EN
  logic [31:0] lines_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lines_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (transfer) lines_cnt <= lines_cnt + 32'd1;
      if ((state == HOLD) && instq_full_i && !redirect_i) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_lines_o = lines_cnt;
  assign perf_stall_o = stall_cnt;
`else
  assign perf_lines_o = '0;
  assign perf_stall_o = '0;
`endif

  rvalid_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid_i |-> ((state == FILL) || (state == DRAIN)));

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Scoreboard bench: a memory model drives beats, a monitor checks grants and line transfers.
module tb_icache_line_fetcher;

`ifdef ICACHE_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         mem_req_o;
  logic [63:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [127:0] mem_rdata_i;
  logic         icache_valid_o;
  logic [63:0]  icache_pc_o;
  logic [511:0] icache_data_o;
  logic         instq_full_i;
  logic         redirect_i;
  logic [63:0]  redirect_pc_i;
  logic [31:0]  perf_lines_o;
  logic [31:0]  perf_stall_o;

  icache_line_fetcher dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .icache_valid_o (icache_valid_o),
    .icache_pc_o    (icache_pc_o),
    .icache_data_o  (icache_data_o),
    .instq_full_i   (instq_full_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .perf_lines_o   (perf_lines_o),
    .perf_stall_o   (perf_stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  int lines_seen = 0;
  logic [63:0] exp_addr[$];
  logic [63:0] exp_pc[$];

  int          beats_left = 0;
  int          wait_cnt = 0;
  int          beat_idx = 0;
  int          gnt_delay = 0;
  bit          gap_mode = 1'b0;
  bit          gap_tgl = 1'b0;
  bit          mem_en = 1'b1;
  logic [63:0] cur_addr = '0;

  function automatic logic [127:0] beat_data(input logic [63:0] a, input int k);
    return {32'hB0A7_0000 + 32'(k), a[31:0], a[63:32], 32'h0000_1111 * 32'(k + 1)};
  endfunction

  function automatic logic [511:0] line_data(input logic [63:0] a);
    logic [511:0] l;
    for (int k = 0; k < 4; k++) l[k*128 +: 128] = beat_data(a, k);
    return l;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_lines(input int n, input string name);
    for (int i = 0; i < 300 && lines_seen < n; i++) step();
    chk(name, 512'(lines_seen >= n), 512'(1));
  endtask

  task automatic wait_grants_done(input string name);
    for (int i = 0; i < 300 && exp_addr.size() != 0; i++) step();
    chk(name, 512'(exp_addr.size()), 512'(0));
  endtask

  task automatic wait_beat(input int k, input string name);
    for (int i = 0; i < 300 && !(mem_rvalid_i && beat_idx == k); i++) step();
    chk(name, 512'(mem_rvalid_i && beat_idx == k), 512'(1));
  endtask

  // Memory model: grant after gnt_delay requesting cycles, then four beats.
  initial begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (!rst_n) begin
        beats_left = 0;
        wait_cnt   = 0;
      end else begin
        if (beats_left > 0 && !(gap_mode && gap_tgl)) begin
          beat_idx     = 4 - beats_left;
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = beat_data(cur_addr, beat_idx);
          beats_left--;
        end
        gap_tgl = !gap_tgl;
        if (mem_en && mem_req_o) begin
          if (wait_cnt >= gnt_delay) begin
            mem_gnt_i  = 1'b1;
            cur_addr   = mem_addr_o;
            beats_left = 4;
            wait_cnt   = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Monitor: every accepted request and every transferred line is checked against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_o && mem_gnt_i) begin
        if (exp_addr.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant: got addr %0h required none", mem_addr_o);
        end else begin
          chk("req_addr", 512'(mem_addr_o), 512'(exp_addr.pop_front()));
        end
      end
      if (icache_valid_o && !instq_full_i) begin
        lines_seen++;
        if (exp_pc.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_line: got pc %0h required none", icache_pc_o);
        end else begin
          logic [63:0] p;
          p = exp_pc.pop_front();
          chk("line_pc", 512'(icache_pc_o), 512'(p));
          chk("line_data", icache_data_o, line_data(p));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    instq_full_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    exp_addr = {64'h8000_0000, 64'h8000_0040, 64'h8000_0080, 64'h8000_00C0, 64'h8000_0100};
    exp_pc   = {64'h8000_0000, 64'h8000_0040, 64'h8000_0080, 64'h8000_00C0};

    step();
    step();
    chk("rst_req", 512'(mem_req_o), 512'(1));
    chk("rst_addr", 512'(mem_addr_o), 512'(64'h8000_0000));
    chk("rst_valid", 512'(icache_valid_o), 512'(0));
    chk("rst_pc", 512'(icache_pc_o), 512'(64'h8000_0000));
    chk("rst_data", icache_data_o, 512'(0));
    chk("rst_perf_lines", 512'(perf_lines_o), 512'(0));
    chk("rst_perf_stall", 512'(perf_stall_o), 512'(0));
    rst_n = 1'b1;

    // Streaming lines, then hold the fourth line against a full queue.
    wait_lines(3, "wait_three_lines");
    instq_full_i = 1'b1;
    for (int i = 0; i < 300 && !icache_valid_o; i++) step();
    chk("wait_hold", 512'(icache_valid_o), 512'(1));
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 512'(icache_valid_o), 512'(1));
      chk("stall_pc", 512'(icache_pc_o), 512'(64'h8000_00C0));
      chk("stall_data", icache_data_o, line_data(64'h8000_00C0));
      step();
    end
    chk("beat0_slot", 512'(icache_data_o[127:0]),
        512'({32'hB0A7_0000, 32'h8000_00C0, 32'h0, 32'h0000_1111}));
    chk("beat3_slot", 512'(icache_data_o[511:384]),
        512'({32'hB0A7_0003, 32'h8000_00C0, 32'h0, 32'h0000_4444}));
    instq_full_i = 1'b0;

    // Redirect in FILL after one beat.
    wait_beat(0, "wait_fill_beat");
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h1234_5678;
    exp_addr.push_back(64'h1234_5640);
    step();
    redirect_i = 1'b0;
    chk("drain_no_req", 512'(mem_req_o), 512'(0));

    // Redirect in HOLD with the queue ready.
    wait_grants_done("wait_grant_12345640");
    wait_beat(3, "wait_last_beat");
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'hABCD_EF01;
    exp_addr.push_back(64'hABCD_EF00);
    #1;
    chk("hold_redirect_mask", 512'(icache_valid_o), 512'(0));
    step();
    redirect_i = 1'b0;
    chk("hold_redirect_req", 512'(mem_req_o), 512'(1));
    chk("hold_redirect_addr", 512'(mem_addr_o), 512'(64'hABCD_EF00));
    chk("perf_lines_mid", 512'(perf_lines_o), 512'(PERF ? 4 : 0));
    chk("perf_stall_mid", 512'(perf_stall_o), 512'(PERF ? 10 : 0));

    // Two redirects, the second landing while draining.
    wait_grants_done("wait_grant_abcdef00");
    wait_beat(0, "wait_drain_beat");
    exp_addr.push_back(64'h2000);
    exp_pc.push_back(64'h2000);
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h5000_0000;
    step();
    redirect_pc_i = 64'h2000;
    step();
    redirect_i = 1'b0;
    chk("second_drain_no_req", 512'(mem_req_o), 512'(0));
    gnt_delay = 7;
    gap_mode  = 1'b1;

    // Redirect in REQ while grant is withheld; target wraps past 2^64.
    exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFC0);
    exp_addr.push_back(64'h0);
    exp_pc.push_back(64'hFFFF_FFFF_FFFF_FFC0);
    exp_pc.push_back(64'h0);
    wait_lines(5, "wait_line_2000");
    step();
    step();
    chk("req_waiting", 512'(mem_req_o), 512'(1));
    chk("req_waiting_addr", 512'(mem_addr_o), 512'(64'h2040));
    redirect_i    = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFD7;
    step();
    redirect_i = 1'b0;
    chk("req_redirect_req", 512'(mem_req_o), 512'(1));
    chk("req_redirect_addr", 512'(mem_addr_o), 512'(64'hFFFF_FFFF_FFFF_FFC0));

    wait_grants_done("wait_grant_wrap");
    mem_en = 1'b0;
    for (int i = 0; i < 300 && exp_pc.size() != 0; i++) step();
    chk("lines_drained", 512'(exp_pc.size()), 512'(0));
    step();
    step();
    chk("final_req", 512'(mem_req_o), 512'(1));
    chk("final_addr", 512'(mem_addr_o), 512'(64'h40));
    chk("final_valid", 512'(icache_valid_o), 512'(0));
    chk("final_lines_seen", 512'(lines_seen), 512'(7));
    chk("perf_lines_end", 512'(perf_lines_o), 512'(PERF ? 7 : 0));
    chk("perf_stall_end", 512'(perf_stall_o), 512'(PERF ? 10 : 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_line_fetcher.md
# icache_line_fetcher

Producer side of the instruction-queue fill interface. Sequentially fetches 64-byte instruction lines from the L2/memory port in 128-bit beats and assembles each into a 512-bit line. Presents the line with its line-aligned PC to the instruction queue under `instq_full` back-pressure. Restarts at a new PC on backend redirect, discarding in-flight data.

## Interface
**Parameters**
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetch address after reset; must be 64B-aligned.
- `MEM_DATA_W`, default 128: memory beat width; 512 must be an integer multiple of it.
- `LINE_W`, default 512: line width; 16 × 32-bit instructions.

**Ports**
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `mem_req_o`, out, 1: line read request.
- `mem_addr_o`, out, 64: line address, low 6 bits zero.
- `mem_gnt_i`, in, 1: request accepted this cycle.
- `mem_rvalid_i`, in, 1: read beat valid.
- `mem_rdata_i`, in, MEM_DATA_W: read beat data.
- `icache_valid_o`, out, 1: assembled line valid.
- `icache_pc_o`, out, 64: PC of instruction 0 of the line.
- `icache_data_o`, out, 512: instruction k in bits [k*32+:32].
- `instq_full_i`, in, 1: queue cannot accept; line is transferred in any cycle with valid && !full.
- `redirect_i`, in, 1: backend redirect; asserted in the same cycle as the queue flush.
- `redirect_pc_i`, in, 64: new fetch PC; bits [5:0] are ignored (forced to 0).
- `perf_lines_o`, out, 32: count of lines delivered.
- `perf_stall_o`, out, 32: count of cycles a line was held while the queue was full.

## Operation
- **Internal state**
  - `fetch_pc`: 64-bit, line-aligned.
  - `beat_cnt`: log2(LINE_W/MEM_DATA_W) bits.
  - `line_buf`: 512 bits.
  - `pend_pc`: redirect target held during drain.
- **FSM states:** REQ, FILL, HOLD, DRAIN. Reset state is REQ with fetch_pc = RESET_PC.
- **REQ**
  - Drives `mem_req_o=1` and `mem_addr_o=fetch_pc`.
  - On `mem_gnt_i`: go to FILL with beat_cnt=0.
  - The request may be withdrawn without grant; only a redirect does so.
- **FILL**
  - Each `mem_rvalid_i` writes `mem_rdata_i` into `line_buf[beat_cnt*MEM_DATA_W +: MEM_DATA_W]` and increments beat_cnt.
  - On the last beat (beat_cnt = max), go to HOLD.
- **HOLD**
  - `icache_valid_o = !redirect_i`, `icache_pc_o = fetch_pc`, `icache_data_o = line_buf`.
  - On a transfer (valid && !full): fetch_pc += 64, wrapping mod 2^64, then go to REQ.
- **Redirect, highest priority**
  - In REQ without grant: fetch_pc ← aligned redirect_pc_i; stay in REQ.
  - In REQ with `mem_gnt_i` in the same cycle, or in FILL: pend_pc ← target; go to DRAIN.
  - In HOLD: discard the line, fetch_pc ← target, go to REQ. `icache_valid_o` is combinationally masked, so no transfer occurs that cycle.
  - In DRAIN: pend_pc is overwritten by the newest target.
- **DRAIN**
  - Consumes and discards the remaining beats of the granted transaction, counted from beat_cnt. When REQ was granted in the redirect cycle, all beats remain.
  - After the last beat: fetch_pc ← pend_pc, go to REQ.
  - A beat arriving in the same cycle as the redirect is counted toward the drain.
- **Outputs in non-HOLD states**
  - `icache_valid_o` = 0.
  - `icache_pc_o` and `icache_data_o` keep their last values; consumers must not sample them.
- `mem_rvalid_i` outside FILL/DRAIN is a protocol violation; assertion only.

## Timing
- **Reset values:**
  - `mem_req_o`=1 (REQ), `mem_addr_o`=RESET_PC.
  - `icache_valid_o`=0, `icache_pc_o`=RESET_PC, `icache_data_o`=0.
  - perf counters 0.
- **Latency:**
  - Last beat at cycle N → `icache_valid_o`=1 at N+1.
  - Transfer at cycle M → `mem_req_o`=1 with new address at M+1.
  - Best-case line turnaround: 1 (grant) + 4 beats + 1 (hold) cycles.
- **Back-pressure:** the line holds stable while `instq_full_i`=1, for any number of cycles.
- **Redirect:** the request for the new PC is asserted the cycle after redirect, or the cycle after the final drained beat.
- **Mid-operation reset:** asynchronously returns to REQ at RESET_PC. Memory-side outstanding beats are the system's responsibility; the whole design resets together.

## Configuration
- `ICACHE_FETCH_PERF_EN` defined:
  - `perf_lines_o` increments on each transfer.
  - `perf_stall_o` increments each cycle in HOLD with `instq_full_i`=1 and no redirect.
  - Both are 32-bit wrapping counters, reset 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package holds:
  - FSM state enum {REQ, FILL, HOLD, DRAIN};
  - `LINE_BYTES`=64;
  - `INSTS_PER_LINE`=16;
  - `BEATS_PER_LINE`=LINE_W/MEM_DATA_W.
- Single flat module. No sub-module; the beat assembler is too small to justify one.

## Test plan
- Reset, always-grant memory, 4 beats per line, queue never full → lines at PC 0x8000_0000, then 0x8000_0040, then 0x8000_0080. Data equals beats concatenated with beat0 in bits [127:0].
- Queue full for 10 cycles during HOLD → valid, pc and data stable for all 10 cycles. `perf_stall_o`=10 with macro, 0 without.
- Redirect to 0x1234_5678 during FILL after 1 beat → 3 beats discarded, then request address 0x1234_5640. No `icache_valid_o` for the old line.
- Redirect in HOLD with queue not full, same cycle → `icache_valid_o`=0 that cycle. Next request goes to the new aligned PC; `perf_lines_o` unchanged.
- Second redirect during DRAIN to 0x2000 → request goes to 0x2000 after the drain completes, not to the first target.
- Grant delayed 7 cycles and redirect in REQ without grant → the next request immediately carries the new address. No drain occurs.
